lcd1602_writer: RTL and testbench



---
 rtl/lcd1602_writer.sv | 207 ++++++++++++++++++++
 tb/tb_lcd1602_writer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_writer.sv
// lcd1602_writer: HD44780 16x2 init sequence, then a two-line refresh from per-frame snapshots.
// Optional LCD_DIRTY_REFRESH_EN: after a frame, redraw only when {top,bottom} differs from it.
module lcd1602_writer #(
  parameter int POWERUP_CYC    = 750000,
  parameter int EN_PULSE_CYC   = 10,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 80000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] top,
  input  logic [127:0] bottom,
  output logic         lcd_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done,
  output logic         busy
);

  localparam int SLOT_MAX_A = (EN_PULSE_CYC > CMD_WAIT_CYC) ? EN_PULSE_CYC : CMD_WAIT_CYC;
  localparam int SLOT_MAX   = (SLOT_MAX_A > CLEAR_WAIT_CYC) ? SLOT_MAX_A : CLEAR_WAIT_CYC;
  localparam int CW         = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int PW         = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC) : 1;

`ifdef LCD_DIRTY_REFRESH_EN
  typedef enum logic [2:0] {
    S_POWERUP, S_INIT, S_L1_ADDR, S_L1_CHAR, S_L2_ADDR, S_L2_CHAR, S_FDONE, S_IDLE_CMP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_POWERUP, S_INIT, S_L1_ADDR, S_L1_CHAR, S_L2_ADDR, S_L2_CHAR, S_FDONE
  } state_t;
`endif

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [CW-1:0]   slot_cnt_q, slot_cnt_d;
  logic [PW-1:0]   pwr_cnt_q, pwr_cnt_d;
  logic [3:0]      col_q, col_d;
  logic            init_done_q, init_done_d;
  logic [127:0]    snap_top_q, snap_bot_q;
`ifdef LCD_DIRTY_REFRESH_EN
  logic [255:0]    last_frame_q;
`endif

  logic            slot_state;
  logic            cur_rs;
  logic [7:0]      cur_byte;
  logic [CW-1:0]   hold_last;

  assign slot_state = (state_q == S_INIT)    || (state_q == S_L1_ADDR) ||
                      (state_q == S_L1_CHAR) || (state_q == S_L2_ADDR) ||
                      (state_q == S_L2_CHAR);

  // Byte presented during the current slot; col_q only moves at slot end, so it is stable.
  always_comb begin
    cur_rs   = 1'b0;
    cur_byte = 8'h00;
    case (state_q)
      S_INIT: begin
        case (col_q[1:0])
          2'd0:    cur_byte = 8'h38;
          2'd1:    cur_byte = 8'h0C;
          2'd2:    cur_byte = 8'h06;
          default: cur_byte = 8'h01;
        endcase
      end
      S_L1_ADDR: cur_byte = 8'h80;
      S_L1_CHAR: begin
        cur_rs   = 1'b1;
        cur_byte = snap_top_q[127 - 8*col_q -: 8];
      end
      S_L2_ADDR: cur_byte = 8'hC0;
      S_L2_CHAR: begin
        cur_rs   = 1'b1;
        cur_byte = snap_bot_q[127 - 8*col_q -: 8];
      end
      default: ;
    endcase
  end

  // Only the clear command needs the long execution wait.
  assign hold_last = (state_q == S_INIT && col_q[1:0] == 2'd3) ? CW'(CLEAR_WAIT_CYC - 1)
                                                               : CW'(CMD_WAIT_CYC - 1);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    slot_cnt_d  = slot_cnt_q;
    pwr_cnt_d   = pwr_cnt_q;
    col_d       = col_q;
    init_done_d = init_done_q;
    case (state_q)
      S_POWERUP: begin
        if (pwr_cnt_q == PW'(POWERUP_CYC - 1)) begin
          state_d   = S_INIT;
          phase_d   = PH_SETUP;
          pwr_cnt_d = '0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 1'b1;
        end
      end
      S_FDONE: begin
`ifdef LCD_DIRTY_REFRESH_EN
        state_d = S_IDLE_CMP;
`else
        state_d = S_L1_ADDR;
`endif
        phase_d = PH_SETUP;
      end
`ifdef LCD_DIRTY_REFRESH_EN
      S_IDLE_CMP: begin
        if ({top, bottom} != last_frame_q) state_d = S_L1_ADDR;
        phase_d = PH_SETUP;
      end
`endif
      default: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d    = PH_PULSE;
            slot_cnt_d = '0;
          end
          PH_PULSE: begin
            if (slot_cnt_q == CW'(EN_PULSE_CYC - 1)) begin
              phase_d    = PH_HOLD;
              slot_cnt_d = '0;
            end else begin
              slot_cnt_d = slot_cnt_q + 1'b1;
            end
          end
          default: begin
            if (slot_cnt_q == hold_last) begin
              phase_d    = PH_SETUP;
              slot_cnt_d = '0;
              col_d      = col_q + 1'b1;
              case (state_q)
                S_INIT: begin
                  if (col_q[1:0] == 2'd3) begin
                    state_d     = S_L1_ADDR;
                    col_d       = '0;
                    init_done_d = 1'b1;
                  end
                end
                S_L1_ADDR: begin
                  state_d = S_L1_CHAR;
                  col_d   = '0;
                end
                S_L1_CHAR: if (col_q == 4'd15) state_d = S_L2_ADDR;
                S_L2_ADDR: begin
                  state_d = S_L2_CHAR;
                  col_d   = '0;
                end
                S_L2_CHAR: if (col_q == 4'd15) state_d = S_FDONE;
                default: ;
              endcase
            end else begin
              slot_cnt_d = slot_cnt_q + 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_POWERUP;
      phase_q     <= PH_SETUP;
      slot_cnt_q  <= '0;
      pwr_cnt_q   <= '0;
      col_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      slot_cnt_q  <= slot_cnt_d;
      pwr_cnt_q   <= pwr_cnt_d;
      col_q       <= col_d;
      init_done_q <= init_done_d;
    end
  end

  // NOTE: frame storage is left unreset; it is always loaded before anything reads it.
  always_ff @(posedge clk) begin
    if (state_d == S_L1_ADDR && state_q != S_L1_ADDR) begin
      snap_top_q <= top;
      snap_bot_q <= bottom;
    end
`ifdef LCD_DIRTY_REFRESH_EN
    if (state_q == S_FDONE) last_frame_q <= {snap_top_q, snap_bot_q};
`endif
  end

  assign lcd_en     = slot_state && (phase_q == PH_PULSE);
  assign lcd_rs     = slot_state ? cur_rs   : 1'b0;
  assign lcd_data   = slot_state ? cur_byte : 8'h00;
  assign lcd_rw     = 1'b0;
  assign busy       = slot_state;
  assign init_done  = init_done_q;
  assign frame_done = (state_q == S_FDONE);

endmodule

// File: tb/tb_lcd1602_writer.sv
// Directed bench for lcd1602_writer with short timing parameters (20/2/4/8).
// Define LCD_DIRTY_REFRESH_EN for both RTL and bench to exercise the dirty-refresh variant.
module tb_lcd1602_writer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] top, bottom;
  logic         lcd_en, lcd_rs, lcd_rw, init_done, frame_done, busy;
  logic [7:0]   lcd_data;

  always #5 clk = ~clk;

  lcd1602_writer #(
    .POWERUP_CYC(20), .EN_PULSE_CYC(2), .CMD_WAIT_CYC(4), .CLEAR_WAIT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .top(top), .bottom(bottom),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .init_done(init_done), .frame_done(frame_done), .busy(busy)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         t;
  } cap_t;

  int   cyc = 0;
  cap_t caps[$];
  int   fd_t[$];
  int   id_t[$];
  int   bad_len = 0, bad_stable = 0, en_len = 0;
  logic en_p = 1'b0, id_p = 1'b0, rs_p = 1'b0;
  logic [7:0] d_p = 8'h00;
  int   passed = 0, total = 0;

  logic [7:0] exp_top [2][16];
  logic [7:0] init_exp [5];

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (lcd_en === 1'b1 && en_p === 1'b0) caps.push_back('{lcd_rs, lcd_data, cyc});
    if (lcd_en === 1'b1) en_len = (en_p === 1'b1) ? en_len + 1 : 1;
    if (lcd_en === 1'b0 && en_p === 1'b1 && !rst && en_len != 2) bad_len++;
    if (lcd_en === 1'b1 && en_p === 1'b1 && (lcd_rs !== rs_p || lcd_data !== d_p)) bad_stable++;
    if (frame_done === 1'b1) fd_t.push_back(cyc);
    if (init_done === 1'b1 && id_p === 1'b0) id_t.push_back(cyc);
    en_p = lcd_en;
    id_p = init_done;
    rs_p = lcd_rs;
    d_p  = lcd_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_caps(input int n, input int budget);
    int k = 0;
    while (caps.size() < n && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("wait_caps_%0d", n), 32'(caps.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input int b, input int sel, input bit flip);
    check("frame_addr1", {23'd0, caps[b].rs, caps[b].data}, 32'h080);
    for (int i = 0; i < 16; i++)
      check($sformatf("frame_l1_c%0d", i), {23'd0, caps[b+1+i].rs, caps[b+1+i].data},
            {23'd0, 1'b1, exp_top[sel][i]});
    check("frame_addr2", {23'd0, caps[b+17].rs, caps[b+17].data}, 32'h0C0);
    for (int i = 0; i < 16; i++)
      check($sformatf("frame_l2_c%0d", i), {23'd0, caps[b+18+i].rs, caps[b+18+i].data},
            {23'd0, 1'b1, (flip && i == 3) ? 8'h23 : 8'h5F});
  endtask

  task automatic check_init(input int b, input int rel);
    for (int i = 0; i < 5; i++)
      check($sformatf("init_byte%0d", i), {23'd0, caps[b+i].rs, caps[b+i].data},
            {24'd0, init_exp[i]});
    check("first_en_latency", caps[b].t - rel, 21);
    check("gap_38_0c", caps[b+1].t - caps[b].t, 7);
    check("gap_0c_06", caps[b+2].t - caps[b+1].t, 7);
    check("gap_06_01", caps[b+3].t - caps[b+2].t, 7);
    check("gap_01_80", caps[b+4].t - caps[b+3].t, 11);
  endtask

  initial begin
    int  rel;
    int  n;
    bit  flip;
    exp_top[0] = '{8'h20, 8'h20, 8'h20, 8'h57, 8'h69, 8'h6E, 8'h20, 8'h20,
                   8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
    exp_top[1] = '{8'h47, 8'h61, 8'h6D, 8'h65, 8'h20, 8'h4F, 8'h76, 8'h65,
                   8'h72, 8'h21, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h07};
    init_exp   = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};
    flip       = 1'b0;
    top        = "   Win          ";
    bottom     = {16{8'h5F}};

    rst = 1'b1;
    repeat (3) tick();
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_data", lcd_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);

    rst = 1'b0;
    rel = cyc;
    wait_caps(5, 400);
    check_init(0, rel);
    check("init_done_rise", (id_t.size() > 0) ? id_t[0] - rel : -1, 52);

    wait_caps(38, 2000);
    check_frame(4, 0, 1'b0);
    check("gap_char", caps[5].t - caps[4].t, 7);

`ifdef LCD_DIRTY_REFRESH_EN
    n = caps.size();
    repeat (500) tick();
    check("idle_no_bytes", caps.size(), n);
    check("idle_one_frame", fd_t.size(), 1);
    check("idle_busy", busy, 0);
    bottom[103:96] = 8'h23;
    flip = 1'b1;
`endif

    // Change top while frame 2 is writing line-1 column 5.
    wait_caps(45, 2000);
    check("frame_done_latency", (fd_t.size() > 0) ? fd_t[0] - (caps[4].t - 1) : -1, 238);
    top = {"Game Over!     ", 8'h07};
    wait_caps(72, 2000);
    check_frame(38, 0, flip);
    wait_caps(106, 2000);
    check_frame(72, 1, flip);
`ifdef LCD_DIRTY_REFRESH_EN
    repeat (100) tick();
    check("idle_after_f3", caps.size(), 106);
    bottom = {16{8'h5F}};
`else
    check("frame_period", (fd_t.size() > 1) ? fd_t[1] - fd_t[0] : -1, 239);
`endif

    // Reset while lcd_en is high on line-2 column 2 of frame 4.
    wait_caps(127, 2000);
    check("en_before_rst", lcd_en, 1);
    check("rs_before_rst", lcd_rs, 1);
    rst = 1'b1;
    tick();
    check("midrst_en", lcd_en, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", lcd_data, 0);
    repeat (2) tick();
    rst = 1'b0;
    rel = cyc;
    n = caps.size();
    wait_caps(n + 5, 400);
    check_init(n, rel);
    check("init_done_rise2", (id_t.size() > 1) ? id_t[1] - rel : -1, 52);

    check("en_pulse_width", bad_len, 0);
    check("bus_stable_in_pulse", bad_stable, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
